pdm_decimator: RTL and testbench

- Receive-side counterpart of pdm_dac: converts a 1-bit PDM stream back into DATA_BITS-wide unsigned PCM samples.
- Implemented as a 3rd-order CIC decimation filter with decimation ratio DECIMATION.
- Uses: loopback self-test of the synth output path, and capture of an external PDM source such as a microphone or a second board's PIN_1.
- Output scale matches pdm_dac: a stream produced by pdm_dac from input value X decodes back to X.

---
 rtl/pdm_decimator.sv | 122 ++++++++++++
 tb/tb_pdm_decimator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pdm_decimator.sv
// 3rd-order CIC decimator turning a 1-bit PDM stream back into PCM samples.
// Define PDM_DECIMATOR_SIGNED_OUT_EN for two's-complement (mid-scale centred) dout.
module pdm_decimator #(
   parameter int DATA_BITS  = 12,
   parameter int DECIMATION = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din,
   input  logic                 din_valid,
   output logic [DATA_BITS-1:0] dout,
   output logic                 dout_valid
);

   localparam int LOG2_DEC = $clog2(DECIMATION);
   localparam int ACC_BITS = 3 * LOG2_DEC + 1;
   localparam int SHIFT    = ACC_BITS - 1 - DATA_BITS;

   typedef logic [ACC_BITS-1:0] acc_t;
   typedef logic [LOG2_DEC-1:0] cnt_t;
   typedef enum logic {WARMUP, RUN} state_e;

   state_e state_q, state_d;
   acc_t i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
   acc_t d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
   cnt_t cnt_q, cnt_d;
   logic [1:0] warm_q, warm_d;
   logic [DATA_BITS-1:0] dout_q, dout_d;
   logic dv_q, dv_d;

   acc_t i1_n, i2_n, i3_n, c1, c2, c3;
   logic tick;
   logic [DATA_BITS-1:0] scaled, out_val;

   always_comb begin
      i1_n = i1_q + {{(ACC_BITS-1){1'b0}}, din};
      i2_n = i2_q + i1_n;
      i3_n = i3_q + i2_n;
      c1   = i3_n - d1_q;
      c2   = c1 - d2_q;
      c3   = c2 - d3_q;
      tick = din_valid && (cnt_q == cnt_t'(DECIMATION - 1));
      // Only a full-scale stream reaches the top bit; clamp it to all ones.
      if (c3[ACC_BITS-1])
         scaled = '1;
      else
         scaled = DATA_BITS'(c3 >> SHIFT);
`ifdef PDM_DECIMATOR_SIGNED_OUT_EN
      out_val = {~scaled[DATA_BITS-1], scaled[DATA_BITS-2:0]};
`else
      out_val = scaled;
`endif
   end

   always_comb begin
      state_d = state_q;
      i1_d    = i1_q;
      i2_d    = i2_q;
      i3_d    = i3_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      d3_d    = d3_q;
      cnt_d   = cnt_q;
      warm_d  = warm_q;
      dout_d  = dout_q;
      dv_d    = 1'b0;
      if (din_valid) begin
         i1_d  = i1_n;
         i2_d  = i2_n;
         i3_d  = i3_n;
         cnt_d = cnt_q + cnt_t'(1);
      end
      if (tick) begin
         d1_d   = i3_n;
         d2_d   = c1;
         d3_d   = c2;
         dout_d = out_val;
         unique case (state_q)
            WARMUP: begin
               if (warm_q == 2'd2)
                  state_d = RUN;
               else
                  warm_d = warm_q + 2'd1;
            end
            RUN: dv_d = 1'b1;
            default: state_d = WARMUP;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WARMUP;
         i1_q    <= '0;
         i2_q    <= '0;
         i3_q    <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         d3_q    <= '0;
         cnt_q   <= '0;
         warm_q  <= '0;
         dout_q  <= '0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         i1_q    <= i1_d;
         i2_q    <= i2_d;
         i3_q    <= i3_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         d3_q    <= d3_d;
         cnt_q   <= cnt_d;
         warm_q  <= warm_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dv_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: FIR-equivalent reference model of the CIC on the raw bit history.
// Build with PDM_DECIMATOR_SIGNED_OUT_EN to check the signed output variant.
module tb_pdm_decimator;

   localparam int DB  = 12;
   localparam int R   = 64;
   localparam int HL  = 3 * R - 2;
   localparam int FS  = R * R * R;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b0;
   logic din_valid = 1'b0;
   logic [DB-1:0] dout;
   logic dout_valid;

   pdm_decimator #(.DATA_BITS(DB), .DECIMATION(R)) dut (
      .clk(clk),
      .rst(rst),
      .din(din),
      .din_valid(din_valid),
      .dout(dout),
      .dout_valid(dout_valid)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   longint h[HL];
   bit hist[$];
   int ticks;
   logic [DB-1:0] exp_dout;
   logic exp_dv;
   int cyc = 0;
   int last_dv = 0;
   int exp_sp = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      if (obs !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Triple boxcar of length R, convolved out to its 3R-2 taps.
   task automatic build_h();
      longint h2[2*R-1];
      for (int k = 0; k < 2*R-1; k++) begin
         h2[k] = 0;
         for (int i = 0; i < R; i++)
            if (k - i >= 0 && k - i < R) h2[k] += 1;
      end
      for (int k = 0; k < HL; k++) begin
         h[k] = 0;
         for (int i = 0; i < R; i++)
            if (k - i >= 0 && k - i < 2*R-1) h[k] += h2[k-i];
      end
   endtask

   function automatic logic [DB-1:0] model_out();
      longint y = 0;
      int n = hist.size() - 1;
      logic [DB-1:0] u;
      for (int j = 0; j < HL; j++)
         if (n - j >= 0 && hist[n-j]) y += h[j];
      if (y >= FS)
         u = '1;
      else
         u = DB'(y / (FS / (1 << DB)));
`ifdef PDM_DECIMATOR_SIGNED_OUT_EN
      u[DB-1] = ~u[DB-1];
`endif
      return u;
   endfunction

   function automatic int to_unsigned(input logic [DB-1:0] v);
`ifdef PDM_DECIMATOR_SIGNED_OUT_EN
      return int'({~v[DB-1], v[DB-2:0]});
`else
      return int'(v);
`endif
   endfunction

   task automatic step(input logic r, input logic d, input logic v);
      @(negedge clk);
      rst = r;
      din = d;
      din_valid = v;
      @(posedge clk);
      cyc++;
      if (r) begin
         hist.delete();
         ticks = 0;
         exp_dout = '0;
         exp_dv = 1'b0;
         last_dv = 0;
      end else begin
         exp_dv = 1'b0;
         if (v) begin
            hist.push_back(d);
            if (hist.size() % R == 0) begin
               ticks++;
               exp_dout = model_out();
               exp_dv = (ticks >= 4);
            end
         end
      end
      #1;
      check("dout", dout, exp_dout);
      check("dout_valid", dout_valid, exp_dv);
      if (dout_valid) begin
         if (last_dv > 0 && exp_sp > 0) check("spacing", cyc - last_dv, exp_sp);
         last_dv = cyc;
      end
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic dac_run(input int x, input int n);
      int acc = 0;
      bit b;
      do_reset(1);
      exp_sp = R;
      for (int i = 0; i < n; i++) begin
         acc += x;
         b = (acc >= 4096);
         if (b) acc -= 4096;
         step(1'b0, b, 1'b1);
      end
      check($sformatf("dac_%0h_pm1", x),
            (to_unsigned(dout) >= x - 1 && to_unsigned(dout) <= x + 1), 1);
   endtask

   initial begin
      int first;
      int density;
      int k;
      logic [DB-1:0] fs_exp;
      build_h();
      ticks = 0;
      exp_dout = '0;
      exp_dv = 1'b0;
`ifdef PDM_DECIMATOR_SIGNED_OUT_EN
      fs_exp = 12'h7FF;
`else
      fs_exp = 12'hFFF;
`endif

      do_reset(3);

      // Full scale: first strobe after 256 samples, then every 64.
      exp_sp = R;
      first = 0;
      for (int i = 0; i < 6 * R; i++) begin
         step(1'b0, 1'b1, 1'b1);
         if (dout_valid) begin
            if (first == 0) first = hist.size();
            check("ones_dout", dout, fs_exp);
         end
      end
      check("ones_first_dv", first, 4 * R);

      do_reset(1);
      for (int i = 0; i < 6 * R; i++) step(1'b0, 1'b0, 1'b1);

      do_reset(1);
      for (int i = 0; i < 6 * R; i++) begin
         step(1'b0, 1'(i % 2 == 0), 1'b1);
         if (dout_valid) check("alt_dout", to_unsigned(dout), 12'h800);
      end

      dac_run(12'h400, 10 * R);
      dac_run(12'hC00, 10 * R);

      // Half-rate valid: state holds on idle cycles, strobes twice as far apart.
      do_reset(1);
      exp_sp = 2 * R;
      k = 0;
      for (int i = 0; i < 14 * R; i++) begin
         if (i % 2 == 0) begin
            step(1'b0, 1'(k % 2 == 0), 1'b1);
            k++;
         end else begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         end
         if (dout_valid) check("half_dout", to_unsigned(dout), 12'h800);
      end

      // Random density and gaps, reset after 100 ticks.
      do_reset(1);
      exp_sp = 0;
      density = $urandom_range(0, 100);
      while (ticks < 100) begin
         if (hist.size() % (8 * R) == 0) density = $urandom_range(0, 100);
         step(1'b0, 1'($urandom_range(0, 99) < density), 1'($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check("rst_dout", dout, 0);
      check("rst_dv", dout_valid, 0);
      first = 0;
      for (int i = 0; i < 12 * R; i++) begin
         step(1'b0, 1'($urandom_range(0, 99) < density), 1'($urandom_range(0, 3) != 0));
         if (dout_valid && first == 0) first = hist.size();
      end
      check("rst_first_dv", first, 4 * R);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
